work_deserializer: RTL
======================

WORK_DESERIALIZER -- requirements
Module: work_deserializer

Interface
REQ-001 SHALL have parameter DATAIN, default 48: FIFO word width; only 48 is supported.
REQ-002 SHALL have parameter SYNC, default 16'hB17C: header sync pattern.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port datain  input  DATAIN  FIFO read data, valid the cycle after rden=1 with empty=0.
REQ-006 SHALL have port empty  input  1  FIFO empty flag.
REQ-007 SHALL have port rden  output  1  FIFO read strobe, registered.
REQ-008 SHALL have port ready  input  1  hasher can accept a new job.
REQ-009 SHALL have port data_hash  output  96  header tail bits for the hasher.
REQ-010 SHALL have port midstate  output  256  SHA-256 midstate.
REQ-011 SHALL have port target  output  256  difficulty target.
REQ-012 SHALL have port job_id  output  8  identifier of the current job.
REQ-013 SHALL have port en  output  1  one-cycle job-start pulse to the hasher.
REQ-014 SHALL have port frame_err  output  1  one-cycle pulse on a discarded word or frame.

Function
REQ-015 Frame format SHALL be: header word H, then payload words P0..P12, then (REQ-029 only) checksum word C.
REQ-016 H SHALL be: [47:32]=SYNC, [31:24]=job id, [23:0] ignored.
REQ-017 {P0,...,P12} (624 bits, P0 most significant) SHALL be {data_hash, midstate, target, 16 pad bits}; pad bits are ignored.
REQ-018 FSM states SHALL be IDLE (hunt H), LOAD (collect payload), CHECK (checksum, REQ-029 only), HOLD (job staged).
REQ-019 rden SHALL be 1 in the next cycle iff empty=0, state is IDLE/LOAD/CHECK, and no more words are needed than are outstanding: at most one read in flight.
REQ-020 In IDLE, a word with [47:32]=SYNC SHALL latch job id, clear the 4-bit word counter and go to LOAD.
REQ-021 In IDLE, a word with [47:32]!=SYNC SHALL be discarded with a frame_err pulse; the FSM stays in IDLE.
REQ-022 In LOAD, each word SHALL shift into a 624-bit staging register and increment the counter; after P12, go to CHECK (REQ-029) or HOLD.
REQ-023 Staging SHALL be separate from the output registers: data_hash/midstate/target/job_id hold the previous job until a commit.
REQ-024 In HOLD, rden SHALL be 0; in the first cycle with ready=1, the outputs SHALL load from staging, en SHALL pulse 1 in the next cycle, and the FSM SHALL return to IDLE.
REQ-025 Latency from the P12 (or C) data cycle with ready=1 held to en=1 SHALL be 2 cycles; the outputs SHALL be valid in the same cycle as en.
REQ-026 empty going high mid-frame SHALL stall without error; the counter holds.
REQ-027 The word counter SHALL never exceed 12; no wrap into a new frame without H.

Reset
REQ-028 With rst_n=0 at a clock edge: state IDLE, counter 0, rden 0, en 0, frame_err 0, data_hash/midstate/target/job_id all 0, staging cleared; a read in flight is discarded and a partial frame is dropped.

Configuration
REQ-029 With macro WORK_DESER_CHECKSUM_EN defined: after P12, the FSM enters CHECK, reads C, and compares it with the XOR of P0..P12. On a match it goes to HOLD; on a mismatch it pulses frame_err, drops the job (outputs unchanged, no en) and returns to IDLE.
REQ-030 Without WORK_DESER_CHECKSUM_EN: the CHECK state and XOR logic are absent, a frame is 14 words, and LOAD goes directly to HOLD.

Verification
REQ-031 Reset: rst_n=0 for 3 cycles with empty=0 -> rden=0, en=0, all outputs 0.
REQ-032 Good frame: job id 8'h5A, data_hash=96'h1, midstate=all-A5, target=256'hFF, ready=1 -> exactly one en pulse 2 cycles after the last word, with the outputs equal to the values sent.
REQ-033 Junk word 48'h0000_1234_5678 before H -> one frame_err pulse, then the frame is accepted normally.
REQ-034 ready=0 for 20 cycles after the frame -> rden=0 and previous outputs unchanged; ready=1 -> en within 1 cycle.
REQ-035 empty toggling every other cycle during LOAD -> same outputs as REQ-032, no frame_err.
REQ-036 With WORK_DESER_CHECKSUM_EN, C corrupted by bit0 flip -> frame_err pulse, no en, outputs retain the prior job; rst_n=0 mid-LOAD followed by a good frame -> en with new values.

Source files
------------

// File: rtl/work_deserializer.sv
// Work deserializer: hunts a SYNC header in a 48-bit FIFO stream, stages a 13-word job and hands it to the hasher.
// Optional trailing XOR checksum word enabled by defining WORK_DESER_CHECKSUM_EN.
module work_deserializer #(
  parameter int          DATAIN = 48,
  parameter logic [15:0] SYNC   = 16'hB17C
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATAIN-1:0] datain,
  input  logic              empty,
  output logic              rden,
  input  logic              ready,
  output logic [95:0]       data_hash,
  output logic [255:0]      midstate,
  output logic [255:0]      target,
  output logic [7:0]        job_id,
  output logic              en,
  output logic              frame_err
);

  localparam int         STAGE_W   = 13 * DATAIN;
  localparam logic [3:0] LAST_WORD = 4'd12;

`ifdef WORK_DESER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
`endif

  state_t              r_state;
  logic [3:0]          r_cnt;
  logic                r_rden;
  logic                r_dvalid;
  logic [STAGE_W-1:0]  r_stage;
  logic [7:0]          r_job_stage;
  logic [95:0]         r_data_hash;
  logic [255:0]        r_midstate;
  logic [255:0]        r_target;
  logic [7:0]          r_job_id;
  logic                r_en;
  logic                r_frame_err;
`ifdef WORK_DESER_CHECKSUM_EN
  logic [DATAIN-1:0]   r_xor;
`endif

  logic w_issue;
  logic w_sync;
  logic w_need;
  logic w_rden_next;

  assign w_issue = r_rden && !empty;
  assign w_sync  = (datain[DATAIN-1 -: 16] == SYNC);

  // A word is still needed unless the one arriving this cycle completes the frame.
  always_comb begin
    w_need = 1'b0;
    case (r_state)
      IDLE:    w_need = 1'b1;
`ifdef WORK_DESER_CHECKSUM_EN
      LOAD:    w_need = 1'b1;
      CHECK:   w_need = !r_dvalid;
`else
      LOAD:    w_need = !(r_dvalid && (r_cnt == LAST_WORD));
`endif
      default: w_need = 1'b0;
    endcase
  end

  assign w_rden_next = !empty && w_need && !w_issue;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_rden      <= 1'b0;
      r_dvalid    <= 1'b0;
      r_stage     <= '0;
      r_job_stage <= 8'd0;
      r_data_hash <= 96'd0;
      r_midstate  <= 256'd0;
      r_target    <= 256'd0;
      r_job_id    <= 8'd0;
      r_en        <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef WORK_DESER_CHECKSUM_EN
      r_xor       <= '0;
`endif
    end else begin
      r_rden      <= w_rden_next;
      r_dvalid    <= w_issue;
      r_en        <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (r_dvalid) begin
            if (w_sync) begin
              r_job_stage <= datain[31:24];
              r_cnt       <= 4'd0;
`ifdef WORK_DESER_CHECKSUM_EN
              r_xor       <= '0;
`endif
              r_state     <= LOAD;
            end else begin
              r_frame_err <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (r_dvalid) begin
            r_stage <= {r_stage[STAGE_W-DATAIN-1:0], datain};
`ifdef WORK_DESER_CHECKSUM_EN
            r_xor   <= r_xor ^ datain;
`endif
            // Counter saturates at the last payload index; the next frame must start with a header.
            if (r_cnt == LAST_WORD) begin
`ifdef WORK_DESER_CHECKSUM_EN
              r_state <= CHECK;
`else
              r_state <= HOLD;
`endif
            end else begin
              r_cnt <= r_cnt + 4'd1;
            end
          end
        end
`ifdef WORK_DESER_CHECKSUM_EN
        CHECK: begin
          if (r_dvalid) begin
            if (datain == r_xor) begin
              r_state <= HOLD;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= IDLE;
            end
          end
        end
`endif
        HOLD: begin
          if (ready) begin
            r_data_hash <= r_stage[STAGE_W-1 -: 96];
            r_midstate  <= r_stage[STAGE_W-97 -: 256];
            r_target    <= r_stage[STAGE_W-353 -: 256];
            r_job_id    <= r_job_stage;
            r_en        <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rden      = r_rden;
  assign data_hash = r_data_hash;
  assign midstate  = r_midstate;
  assign target    = r_target;
  assign job_id    = r_job_id;
  assign en        = r_en;
  assign frame_err = r_frame_err;

endmodule
